// File: rtl/fixed_float_pkg.sv
// Shared constants and opcode encoding for the fixed/float converter.
package fixed_float_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 23;
    localparam int unsigned EXP_BIAS = 127;

    typedef enum logic {
        OP_FIX2FLT = 1'b0,
        OP_FLT2FIX = 1'b1
    } op_e;

endpackage : fixed_float_pkg

// File: rtl/lod32.sv
// Combinational leading-one detector: index of the most significant set bit.
module lod32 (
    input  logic [31:0] in_vec,
    output logic [4:0]  idx,
    output logic        valid
);

    always_comb begin
        idx = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (in_vec[i]) begin
                idx = 5'(i);
            end
        end
        valid = |in_vec;
    end

endmodule : lod32

// File: rtl/fixed_float_conversion.sv
// Single-cycle fixed-point <-> IEEE-754 single converter with one output register.
module fixed_float_conversion
    import fixed_float_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] targetnumber,
    input  logic [4:0]  fixpointpos,
    input  logic        opcode,
    output logic [31:0] result
);

    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] result_d;

    // fixed -> float datapath
    logic              fx_sign;
    logic [DATA_W-1:0] fx_mag;
    logic [4:0]        fx_lead;
    logic              fx_nonzero;
    logic [DATA_W-1:0] fx_norm;
    logic [EXP_W-1:0]  fx_exp;
    logic [MAN_W-1:0]  fx_man;
    logic [DATA_W-1:0] fx_out;

    // float -> fixed datapath
    logic              fl_sign;
    logic [EXP_W-1:0]  fl_exp;
    logic [63:0]       fl_sig;
    logic signed [9:0] fl_shift;
    logic signed [9:0] fl_rshift;
    logic [63:0]       fl_mag;
    logic              fl_ovf;
    logic              fl_sat;
    logic [DATA_W-1:0] fl_out;

    lod32 u_lod32 (
        .in_vec (fx_mag),
        .idx    (fx_lead),
        .valid  (fx_nonzero)
    );

    // Two's-complement magnitude; 0x80000000 naturally maps to 2^31 unsigned.
    always_comb begin
        fx_sign = targetnumber[DATA_W-1];
        fx_mag  = fx_sign ? (~targetnumber + 32'd1) : targetnumber;
        fx_norm = fx_mag << (5'd31 - fx_lead);
        fx_exp  = EXP_W'(EXP_BIAS + 32'(fx_lead) - 32'(fixpointpos));
        fx_man  = MAN_W'(fx_norm >> 8);
        fx_out  = fx_nonzero ? {fx_sign, fx_exp, fx_man} : '0;
    end

    // Shift distance can reach +135 / -149, so work in 10-bit signed and 64-bit magnitude.
    always_comb begin
        fl_sign   = targetnumber[DATA_W-1];
        fl_exp    = targetnumber[DATA_W-2 -: EXP_W];
        fl_sig    = {40'd0, 1'b1, targetnumber[MAN_W-1:0]};
        fl_shift  = $signed({2'b00, fl_exp}) - 10'sd127
                  + $signed({5'b00000, fixpointpos}) - 10'sd23;
        fl_rshift = -fl_shift;
        fl_mag    = '0;
        fl_ovf    = 1'b0;
        if (fl_shift >= 10'sd0) begin
            if (fl_shift > 10'sd40) begin
                fl_ovf = 1'b1;
            end else begin
                fl_mag = fl_sig << 6'(fl_shift);
            end
        end else if (fl_rshift < 10'sd24) begin
            fl_mag = fl_sig >> 6'(fl_rshift);
        end
        fl_sat = fl_ovf || (fl_exp == 8'hFF)
              || (!fl_sign && (fl_mag > 64'h0000_0000_7FFF_FFFF))
              || ( fl_sign && (fl_mag > 64'h0000_0000_8000_0000));
        if (fl_exp == 8'h00) begin
            fl_out = '0;
        end else if (fl_sat) begin
            fl_out = fl_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (fl_sign) begin
            fl_out = ~fl_mag[31:0] + 32'd1;
        end else begin
            fl_out = fl_mag[31:0];
        end
    end

    always_comb begin
        result_d = (op_e'(opcode) == OP_FLT2FIX) ? fl_out : fx_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule : fixed_float_conversion

// File: tb/tb_fixed_float_conversion.sv
// Directed-vector bench for fixed_float_conversion with hand-computed expectations.
module tb_fixed_float_conversion;

    logic        clk;
    logic        rst;
    logic [31:0] targetnumber;
    logic [4:0]  fixpointpos;
    logic        opcode;
    logic [31:0] result;

    int n_cmp;
    int n_bad;

    fixed_float_conversion dut (
        .clk          (clk),
        .rst          (rst),
        .targetnumber (targetnumber),
        .fixpointpos  (fixpointpos),
        .opcode       (opcode),
        .result       (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
        end
    endtask

    // Drive on the falling edge, check 1 time unit after the following rising edge.
    task automatic run_vec(input string tag, input logic op, input logic [4:0] fp,
                           input logic [31:0] tn, input logic [31:0] want);
        @(negedge clk);
        opcode       = op;
        fixpointpos  = fp;
        targetnumber = tn;
        @(posedge clk);
        #1;
        check_val(tag, result, want);
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst          = 1'b0;
        opcode       = 1'b0;
        fixpointpos  = 5'd2;
        targetnumber = 32'h0000_0065;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_hold", result, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b1;

        // fixed -> float
        run_vec("fx2fl_25p25",    1'b0, 5'd2,  32'h0000_0065, 32'h41CA_0000);
        run_vec("fx2fl_neg25p25", 1'b0, 5'd2,  32'hFFFF_FF9B, 32'hC1CA_0000);
        run_vec("fx2fl_zero",     1'b0, 5'd2,  32'h0000_0000, 32'h0000_0000);
        run_vec("fx2fl_one",      1'b0, 5'd0,  32'h0000_0001, 32'h3F80_0000);
        run_vec("fx2fl_minint",   1'b0, 5'd0,  32'h8000_0000, 32'hCF00_0000);
        run_vec("fx2fl_maxint",   1'b0, 5'd0,  32'h7FFF_FFFF, 32'h4EFF_FFFF);
        run_vec("fx2fl_fp31",     1'b0, 5'd31, 32'h0000_0001, 32'h3000_0000);
        run_vec("fx2fl_trunc",    1'b0, 5'd0,  32'h0100_0001, 32'h4B80_0000);

        // float -> fixed
        run_vec("fl2fx_25p25",    1'b1, 5'd2,  32'h41CA_0000, 32'h0000_0065);
        run_vec("fl2fx_neg25p25", 1'b1, 5'd2,  32'hC1CA_0000, 32'hFFFF_FF9B);
        run_vec("fl2fx_sat_pos",  1'b1, 5'd0,  32'h5380_0000, 32'h7FFF_FFFF);
        run_vec("fl2fx_sat_neg",  1'b1, 5'd0,  32'hD380_0000, 32'h8000_0000);
        run_vec("fl2fx_half",     1'b1, 5'd0,  32'h3F00_0000, 32'h0000_0000);
        run_vec("fl2fx_inf",      1'b1, 5'd0,  32'h7F80_0000, 32'h7FFF_FFFF);
        run_vec("fl2fx_ninf",     1'b1, 5'd0,  32'hFF80_0000, 32'h8000_0000);
        run_vec("fl2fx_denorm",   1'b1, 5'd0,  32'h0040_0000, 32'h0000_0000);
        run_vec("fl2fx_2p31",     1'b1, 5'd0,  32'h4F00_0000, 32'h7FFF_FFFF);
        run_vec("fl2fx_m2p31",    1'b1, 5'd0,  32'hCF00_0000, 32'h8000_0000);
        run_vec("fl2fx_one_fp31", 1'b1, 5'd31, 32'h3F80_0000, 32'h7FFF_FFFF);
        run_vec("fl2fx_half_fp31",1'b1, 5'd31, 32'h3F00_0000, 32'h4000_0000);
        run_vec("fl2fx_m1p5_fp4", 1'b1, 5'd4,  32'hBFC0_0000, 32'hFFFF_FFE8);
        run_vec("fl2fx_1p75",     1'b1, 5'd0,  32'h3FE0_0000, 32'h0000_0001);

        // Asynchronous reset mid-stream, then recovery
        run_vec("pre_reset",      1'b0, 5'd2,  32'h0000_0065, 32'h41CA_0000);
        #2;
        rst          = 1'b0;
        opcode       = 1'b1;
        fixpointpos  = 5'd2;
        targetnumber = 32'hC1CA_0000;
        #1;
        check_val("async_clear", result, 32'h0000_0000);
        @(posedge clk);
        #1;
        check_val("reset_blocks_edge", result, 32'h0000_0000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("post_reset", result, 32'hFFFF_FF9B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fixed_float_conversion
